// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared state encoding, frame geometry and command-bit helper for adc_reader
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    CS_HIGH = 2'd2
  } state_t;

  localparam int FRAME_BITS = 17;
  localparam int NULL_BIT   = 4;
  localparam int DATA_BITS  = 12;
  // Null bit plus data bits; earlier samples fall off the top of the shift register.
  localparam int SHIFT_W    = FRAME_BITS - NULL_BIT;

  function automatic logic cmd_bit(input logic [4:0] k, input logic diff, input logic ch);
    case (k)
      5'd0:    return 1'b1;
      5'd1:    return ~diff;
      5'd2:    return ch;
      5'd3:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sclk_gen.sv
// rtl/sclk_gen.sv - half-period counter producing tick/rise/fall strobes and the registered serial clock
module sclk_gen #(
  parameter int HALF_PERIOD = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic toggle_en,
  output logic tick,
  output logic rise,
  output logic fall,
  output logic sclk
);

  localparam int CW = $clog2(HALF_PERIOD + 1);

  logic [CW-1:0] cnt;

  // Strobes mark the edge on which sclk will change, so the top can act on that same edge.
  assign tick = run && (cnt == CW'(HALF_PERIOD - 1));
  assign rise = tick && toggle_en && !sclk;
  assign fall = tick && toggle_en && sclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!run) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (rise || fall) sclk <= ~sclk;
    end
  end

endmodule

// File: rtl/adc_reader.sv
// rtl/adc_reader.sv - SPI mode 0,0 reader for a two-channel 12-bit ADC with null-bit check
import adc_pkg::*;

module adc_reader #(
  parameter int HALF_PERIOD = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 ch,
  input  logic                 diff,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_BITS-1:0] dout,
  output logic                 null_err,
  output logic                 adc_cs,
  output logic                 adc_clk,
  output logic                 adc_di,
  input  logic                 adc_do
);

  localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);

  state_t             state, state_n;
  logic [4:0]         bcnt;
  logic [SHIFT_W-1:0] shreg;
  logic               ch_q, diff_q;
  logic               tick, rise, fall;
  logic               accept, finish, go_idle;

  sclk_gen #(.HALF_PERIOD(HALF_PERIOD)) u_sclk (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (state != IDLE),
    .toggle_en (state == XFER),
    .tick      (tick),
    .rise      (rise),
    .fall      (fall),
    .sclk      (adc_clk)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    finish  = 1'b0;
    go_idle = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept  = 1'b1;
        state_n = XFER;
      end
      XFER: if (fall && bcnt == LAST_BIT) begin
        finish  = 1'b1;
        state_n = CS_HIGH;
      end
      // A held start re-arms on the IDLE-entry edge, keeping the CS-high gap at 2H.
      CS_HIGH: if (tick && bcnt == 5'd1) begin
        if (start) begin
          accept  = 1'b1;
          state_n = XFER;
        end else begin
          go_idle = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_cs   <= 1'b1;
      adc_di   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dout     <= '0;
      null_err <= 1'b0;
      bcnt     <= '0;
      ch_q     <= 1'b0;
      diff_q   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        adc_cs <= 1'b0;
        adc_di <= cmd_bit(5'd0, diff, ch);
        busy   <= 1'b1;
        ch_q   <= ch;
        diff_q <= diff;
        bcnt   <= '0;
      end else if (finish) begin
        adc_cs   <= 1'b1;
        adc_di   <= 1'b0;
        dout     <= shreg[DATA_BITS-1:0];
        null_err <= shreg[DATA_BITS];
        done     <= 1'b1;
        bcnt     <= '0;
      end else if (go_idle) begin
        busy <= 1'b0;
        bcnt <= '0;
      end else if (state == XFER && fall) begin
        bcnt   <= bcnt + 5'd1;
        adc_di <= cmd_bit(bcnt + 5'd1, diff_q, ch_q);
      end else if (state == CS_HIGH && tick) begin
        bcnt <= bcnt + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    shreg <= '0;
    else if (rise) shreg <= {shreg[SHIFT_W-2:0], adc_do};
  end

endmodule

// File: doc/adc_reader.md
ADC_READER -- requirements
Module: adc_reader

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 1, clk cycles per adc_clk half-period (legal range 1..255).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  request one conversion; sampled only in IDLE.
REQ-005 SHALL have port ch  input  1  channel select (0 = CH0, 1 = CH1), latched at start acceptance.
REQ-006 SHALL have port diff  input  1  1 = pseudo-differential mode, 0 = single-ended; latched at start acceptance.
REQ-007 SHALL have port busy  output  1  high from start acceptance until return to IDLE.
REQ-008 SHALL have port done  output  1  single-cycle pulse when dout is updated.
REQ-009 SHALL have port dout  output  12  last converted sample, held between conversions.
REQ-010 SHALL have port null_err  output  1  null bit sampled high on last conversion; updated with dout.
REQ-011 SHALL have ports adc_cs (output 1, active-low chip select), adc_clk (output 1, serial clock), adc_di (output 1, command to ADC), adc_do (input 1, data from ADC).

Function
REQ-012 SHALL run SPI mode 0,0: adc_clk idles low; adc_di changes only while adc_clk low; adc_do sampled on the clk edge that drives adc_clk high.
REQ-013 SHALL have states IDLE, XFER, CS_HIGH; IDLE->XFER on start; XFER->CS_HIGH after bit 16; CS_HIGH->IDLE after 2*HALF_PERIOD cycles.
REQ-014 SHALL, at accepting edge E0: drive adc_cs low, adc_clk low, adc_di = bit 0, assert busy, latch ch/diff.
REQ-015 SHALL frame 17 bits k = 0..16; adc_clk rises at E0 + H + 2Hk, falls at E0 + 2H(k+1) (H = HALF_PERIOD).
REQ-016 SHALL drive adc_di: k0 = 1 (start), k1 = ~diff (SGL/DIFF), k2 = ch (ODD/SIGN), k3 = 1 (MSBF), k4..k16 = 0.
REQ-017 SHALL treat sample k4 as null bit and samples k5..k16 as dout[11]..dout[0], MSB first.
REQ-018 SHALL, at E0 + 34H: drive adc_cs high, update dout and null_err, pulse done for one cycle, enter CS_HIGH.
REQ-019 SHALL keep busy high through CS_HIGH; busy falls when state returns to IDLE (E0 + 36H).
REQ-020 SHALL ignore start while busy; start held high continuously SHALL begin a new conversion at each IDLE entry.
REQ-021 SHALL shift incoming bits into a separate register; dout SHALL not change before the done edge.
REQ-022 SHALL use a half-period counter of width ceil(log2(HALF_PERIOD+1)) and a 5-bit bit counter; neither wraps mid-frame.

Reset
REQ-023 SHALL on rst_n low, asynchronously: state IDLE, adc_cs = 1, adc_clk = 0, adc_di = 0, busy = 0, done = 0, dout = 0, null_err = 0, counters = 0.
REQ-024 SHALL abort a conversion in progress on reset with no done pulse; dout retains reset value 0.
REQ-025 SHALL accept start no earlier than the first rising clk edge after rst_n deasserts.

Structure
REQ-026 SHALL place state encoding, FRAME_BITS = 17, NULL_BIT = 4, DATA_BITS = 12 in shared package adc_pkg.
REQ-027 SHALL implement adc_clk generation as sub-module sclk_gen (half-period counter, rise/fall strobes).
REQ-028 SHALL register all outputs; no combinational path from adc_do to any output.

Verification
REQ-029 SHALL test H=1, ch=0, diff=0, model returns 0xA5C -> adc_di = 1,1,0,1; done at E0+34; dout = 0xA5C; null_err = 0.
REQ-030 SHALL test H=3, ch=1, diff=1, model returns 0x001 -> adc_di = 1,0,1,1; adc_clk period 6 cycles; done at E0+102; dout = 0x001.
REQ-031 SHALL test start pulsed at E0+10 (busy) -> ignored; one frame only; single done pulse.
REQ-032 SHALL test rst_n low at E0+20 -> adc_cs = 1 and adc_clk = 0 immediately; no done; dout = 0; next start yields full frame.
REQ-033 SHALL test model driving null bit = 1 with data 0xFFF -> null_err = 1, dout = 0xFFF; next clean frame clears null_err.
REQ-034 SHALL test start held high for 3 frames, H=1 -> adc_cs high exactly 2 cycles between frames; done at E0+34, E0+70, E0+106.
